// File: rtl/edge_capture_sched.sv
// Round-robin scheduler for one shared dual-edge capture path: grant, settle, capture BURST pairs, deliver.
// Optional EDGE_SCHED_ABORT_EN: a granted requester dropping req during SETTLE/CAPTURE aborts the burst.
module edge_capture_sched #(
  parameter int BURST  = 8,
  parameter int SETTLE = 2
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic [3:0]         req,
  input  logic [1:0]         pair_in,
  input  logic               data_ready,
  output logic [3:0]         grant,
  output logic [1:0]         sel,
  output logic               cap_en,
  output logic [2*BURST-1:0] data_out,
  output logic               data_valid,
  output logic [1:0]         data_id
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CAPTURE, S_DELIVER} state_t;

  state_t             state_q, state_d;
  logic [3:0]         grant_q, grant_d;
  logic [1:0]         sel_q, sel_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [2*BURST-1:0] data_q, data_d;
  logic [1:0]         id_q, id_d;
  logic [2*BURST-1:0] shift_nx;
  logic [1:0]         win, idx;
  logic               found;
  logic               abort;

  // Oldest pair ends up in the MSBs; a single-pair burst is just the input.
  if (BURST > 1) begin : g_shift
    assign shift_nx = {data_q[2*BURST-3:0], pair_in};
  end else begin : g_single
    assign shift_nx = pair_in;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    id_d    = id_q;
    win     = '0;
    idx     = '0;
    found   = 1'b0;
    abort   = 1'b0;
`ifdef EDGE_SCHED_ABORT_EN
    abort   = ~req[sel_q];
`endif

    for (int unsigned i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_SETTLE;
          grant_d = 4'b0001 << win;
          sel_d   = win;
          cnt_d   = '0;
        end
      end
      S_SETTLE: begin
        if (abort) begin
          state_d = S_IDLE;
          grant_d = '0;
          ptr_d   = sel_q + 2'd1;
          cnt_d   = '0;
        end else if (cnt_q == 4'(SETTLE - 1)) begin
          state_d = S_CAPTURE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_CAPTURE: begin
        if (abort) begin
          state_d = S_IDLE;
          grant_d = '0;
          ptr_d   = sel_q + 2'd1;
          cnt_d   = '0;
        end else begin
          data_d = shift_nx;
          if (cnt_q == 4'(BURST - 1)) begin
            state_d = S_DELIVER;
            id_d    = sel_q;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      S_DELIVER: begin
        if (data_ready) begin
          state_d = S_IDLE;
          grant_d = '0;
          ptr_d   = sel_q + 2'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      id_q    <= id_d;
    end
  end

  assign grant      = grant_q;
  assign sel        = sel_q;
  assign cap_en     = (state_q == S_CAPTURE);
  assign data_valid = (state_q == S_DELIVER);
  assign data_out   = data_q;
  assign data_id    = id_q;

endmodule

// File: tb/tb_edge_capture_sched.sv
// Directed bench for edge_capture_sched (BURST=8, SETTLE=2); honours EDGE_SCHED_ABORT_EN when defined.
module tb_edge_capture_sched;
  localparam int BURST  = 8;
  localparam int SETTLE = 2;

  logic        clk = 1'b0;
  logic        rstb;
  logic [3:0]  req;
  logic [1:0]  pair_in;
  logic        data_ready;
  logic [3:0]  grant;
  logic [1:0]  sel;
  logic        cap_en;
  logic [15:0] data_out;
  logic        data_valid;
  logic [1:0]  data_id;

  int total = 0;
  int bad   = 0;

  edge_capture_sched #(.BURST(BURST), .SETTLE(SETTLE)) dut (
    .clk        (clk),
    .rstb       (rstb),
    .req        (req),
    .pair_in    (pair_in),
    .data_ready (data_ready),
    .grant      (grant),
    .sel        (sel),
    .cap_en     (cap_en),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_id    (data_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge in IDLE with req set; returns at the negedge where data_valid is first seen.
  task automatic run_burst(input string tag, input logic [3:0] eg, input logic [1:0] es,
                           input logic [15:0] pairs);
    int t;
    int capn;
    bit sel_ok;
    @(negedge clk);
    check({tag, "_grant"}, 32'(grant), 32'(eg));
    check({tag, "_sel"}, 32'(sel), 32'(es));
    t = 0;
    capn = 0;
    sel_ok = 1'b1;
    while (!data_valid && t < 60) begin
      if (sel !== es) sel_ok = 1'b0;
      if (cap_en) begin
        if (capn < 8) pair_in = pairs[15-2*capn -: 2];
        capn++;
      end
      @(negedge clk);
      t++;
    end
    check({tag, "_valid_seen"}, 32'(data_valid), 32'd1);
    check({tag, "_latency"}, 32'(t), 32'(SETTLE + BURST));
    check({tag, "_cap_cycles"}, 32'(capn), 32'(BURST));
    check({tag, "_sel_stable"}, 32'(sel_ok), 32'd1);
    check({tag, "_data"}, 32'(data_out), 32'(pairs));
    check({tag, "_id"}, 32'(data_id), 32'(es));
  endtask

  // With data_ready high, the word releases on the next edge and the FSM sits in IDLE for a cycle.
  task automatic release_check(input string tag);
    @(negedge clk);
    check({tag, "_valid_clr"}, 32'(data_valid), 32'd0);
    check({tag, "_idle_gap"}, 32'(grant), 32'd0);
  endtask

  task automatic count_no_valid(input string tag, input int cycles);
    int vcount;
    vcount = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (data_valid) vcount++;
    end
    check({tag, "_no_valid"}, 32'(vcount), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstb = 1'b0;
    req = 4'b0000;
    pair_in = 2'b00;
    data_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("reset_outputs", 32'({grant, sel, cap_en, data_out, data_valid, data_id}), 32'd0);
    rstb = 1'b1;
    @(negedge clk);

    // Single requester 2, constant 10 pairs.
    req = 4'b0100;
    pair_in = 2'b10;
    run_burst("basic", 4'b0100, 2'd2, 16'hAAAA);
    req = 4'b0000;
    release_check("basic");

    // ptr is now 3: requester 3 must beat requester 0; pair sequence 11,00,01,10,...
    req = 4'b1001;
    run_burst("ptr3_seq", 4'b1000, 2'd3, 16'b1100011011000110);
    req = 4'b0000;
    release_check("ptr3_seq");

    // Back-pressure: ready low for 5 cycles after valid.
    data_ready = 1'b0;
    req = 4'b0010;
    run_burst("stall", 4'b0010, 2'd1, 16'h3C96);
    req = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_hold", 32'({data_valid, data_id, data_out}), 32'({1'b1, 2'd1, 16'h3C96}));
    end
    data_ready = 1'b1;
    release_check("stall_release");

    // Fresh reset, all requesters held: rotation 0,1,2,3,0.
    rstb = 1'b0;
    @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
    req = 4'b1111;
    run_burst("rr0", 4'b0001, 2'd0, 16'h1234);
    release_check("rr0");
    run_burst("rr1", 4'b0010, 2'd1, 16'h5678);
    release_check("rr1");
    run_burst("rr2", 4'b0100, 2'd2, 16'h9ABC);
    release_check("rr2");
    run_burst("rr3", 4'b1000, 2'd3, 16'hDEF0);
    release_check("rr3");
    run_burst("rr4", 4'b0001, 2'd0, 16'h0F0F);
    req = 4'b0000;
    release_check("rr4");

    // ptr is 1; reset during the 4th capture cycle, then ptr must restart at 0.
    req = 4'b0100;
    pair_in = 2'b11;
    @(negedge clk);
    check("rst_mid_grant", 32'(grant), 32'b0100);
    repeat (5) @(negedge clk);
    check("rst_mid_in_capture", 32'(cap_en), 32'd1);
    rstb = 1'b0;
    req = 4'b0000;
    #1;
    check("rst_mid_outputs", 32'({grant, sel, cap_en, data_out, data_valid, data_id}), 32'd0);
    @(negedge clk);
    rstb = 1'b1;
    count_no_valid("rst_mid", 14);
    req = 4'b1001;
    run_burst("post_rst", 4'b0001, 2'd0, 16'h2DB4);
    req = 4'b0000;
    release_check("post_rst");

    // Requester 1 drops req during its 3rd capture cycle.
    req = 4'b0010;
    pair_in = 2'b01;
    @(negedge clk);
    check("drop_grant", 32'(grant), 32'b0010);
    repeat (4) @(negedge clk);
    check("drop_in_capture", 32'(cap_en), 32'd1);
    req = 4'b0000;
    @(negedge clk);
`ifdef EDGE_SCHED_ABORT_EN
    check("drop_abort_state", 32'({grant, cap_en, data_valid}), 32'd0);
    count_no_valid("drop_abort", 14);
`else
    begin
      int t;
      t = 0;
      check("drop_still_capturing", 32'(cap_en), 32'd1);
      while (!data_valid && t < 30) begin
        @(negedge clk);
        t++;
      end
      check("drop_valid_seen", 32'(data_valid), 32'd1);
      check("drop_data", 32'(data_out), 32'h5555);
      check("drop_id", 32'(data_id), 32'd1);
      release_check("drop");
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/edge_capture_sched.md
EDGE_CAPTURE_SCHED -- requirements
Module: edge_capture_sched

Interface
REQ-001 SHALL have parameter BURST, default 8: number of dual-edge sample pairs captured per grant (legal 1..16).
REQ-002 SHALL have parameter SETTLE, default 2: idle cycles after switching the shared input before capture starts (legal 1..7).
REQ-003 SHALL have port clk  input  1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rstb  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port req  input  4: per-requester capture request, level-sensitive.
REQ-006 SHALL have port pair_in  input  2: shared dual-edge capture path outputs; [1] is the rising-edge sample, [0] is the falling-edge sample.
REQ-007 SHALL have port data_ready  input  1: consumer accepts data_out.
REQ-008 SHALL have port grant  output  4: one-hot grant; all zero when no requester is granted.
REQ-009 SHALL have port sel  output  2: index of the granted requester, routed to the shared datapath d input mux.
REQ-010 SHALL have port cap_en  output  1: high while pair_in is being sampled.
REQ-011 SHALL have port data_out  output  2*BURST: assembled capture word.
REQ-012 SHALL have port data_valid  output  1: data_out is valid.
REQ-013 SHALL have port data_id  output  2: requester index that owns data_out.

Function
REQ-014 SHALL implement FSM states IDLE, SETTLE, CAPTURE and DELIVER.
REQ-015 IDLE: when any req bit is high, SHALL pick the winner round-robin starting at pointer ptr, assert grant/sel on the next edge, and enter SETTLE.
REQ-016 SETTLE: SHALL count SETTLE cycles with cap_en low, then enter CAPTURE.
REQ-017 CAPTURE: SHALL hold cap_en high for exactly BURST cycles and shift per cycle as data_out <= {data_out[2*BURST-3:0], pair_in}, so the first pair lands in the MSBs.
REQ-018 CAPTURE end: SHALL enter DELIVER with data_valid=1 and data_id=sel on the edge after the last sample.
REQ-019 DELIVER: SHALL hold data_valid, data_out and data_id stable until data_valid & data_ready is sampled, then clear data_valid, clear grant, set ptr=(winner+1) mod 4, and return to IDLE.
REQ-020 Total latency from grant to data_valid SHALL be SETTLE+BURST cycles.
REQ-021 When multiple requests arrive simultaneously, SHALL select the first asserted index at or after ptr, wrapping 3 to 0.
REQ-022 SHALL ignore changes on req outside IDLE except as given in REQ-029.
REQ-023 sel SHALL remain constant from grant until return to IDLE; no glitch or change while cap_en is high.
REQ-024 If data_ready is already high when data_valid rises, the handshake SHALL complete in that single DELIVER cycle.
REQ-025 An IDLE cycle SHALL always separate consecutive grants.

Reset
REQ-026 On rstb low, SHALL immediately and asynchronously set state=IDLE, grant=0, sel=0, cap_en=0, data_out=0, data_valid=0, data_id=0, ptr=0, and counters=0.
REQ-027 Reset mid-CAPTURE or mid-DELIVER SHALL discard the partial or undelivered word with no data_valid pulse.
REQ-028 After rstb deassertion, arbitration SHALL resume from ptr=0.

Configuration
REQ-029 When EDGE_SCHED_ABORT_EN is defined: if req[sel] drops during SETTLE or CAPTURE, SHALL return to IDLE on the next edge with no data_valid, clear grant and cap_en, and advance ptr as in REQ-019.
REQ-030 When EDGE_SCHED_ABORT_EN is undefined: a dropped req SHALL be ignored and the burst SHALL complete and deliver normally.

Verification
REQ-031 Reset, then req=4'b0100, BURST=8, SETTLE=2, pair_in=2'b10 constant, data_ready=1 -> grant=4'b0100 and sel=2 one cycle later; cap_en high for 8 cycles; data_out=16'hAAAA, data_id=2; data_valid for 1 cycle; then ptr=3.
REQ-032 req=4'b1111 held, data_ready=1 -> grants in order 0,1,2,3,0, each separated by one IDLE cycle.
REQ-033 Single request, data_ready=0 for 5 cycles after data_valid -> data_valid, data_out and data_id stable for all 5 cycles; release occurs on the first cycle ready is sampled high.
REQ-034 pair_in sequence 11,00,01,10,11,00,01,10 -> data_out=16'b1100011011000110.
REQ-035 rstb pulsed low during the 4th CAPTURE cycle -> all outputs 0 immediately; no data_valid; next request to requester 0 is granted first.
REQ-036 req[1] dropped in the 3rd CAPTURE cycle -> with EDGE_SCHED_ABORT_EN: IDLE next edge, no data_valid; without it: full word delivered with data_id=1.
